// File: rtl/regs_wb_arbiter_if.sv
// Writeback-side bundle for regs_wb_arbiter: two write requesters, issue tracking,
// ID source addresses and the regfile write port.
interface regs_wb_arbiter_if;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;

    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;

    logic        issue_i;
    logic [4:0]  issue_waddr_i;

    logic [4:0]  id_raddr1_i;
    logic [4:0]  id_raddr2_i;
    logic        stall_o;

    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output issue_i, issue_waddr_i,
        output id_raddr1_i, id_raddr2_i,
        input  ex_ready_o, lsu_ready_o, stall_o,
        input  reg_wen_o, reg_waddr_o, reg_wdata_o
    );

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  issue_i, issue_waddr_i,
        input  id_raddr1_i, id_raddr2_i,
        output ex_ready_o, lsu_ready_o, stall_o,
        output reg_wen_o, reg_waddr_o, reg_wdata_o
    );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Regfile write-port arbiter (EX vs LSU, 1-cycle registered write) with a
// pending-write scoreboard for long-latency ops; LSU is promoted after STARVE_MAX losses.
module regs_wb_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    regs_wb_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_busy;
    logic             r_wen;
    logic [4:0]       r_waddr;
    logic [31:0]      r_wdata;

    logic        w_lsu_pri;
    logic        w_ex_grant;
    logic        w_lsu_grant;
    logic        w_accept;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic [31:0] w_busy_nxt;

    assign w_lsu_pri   = int'(r_wait_cnt) >= STARVE_MAX;
    assign w_lsu_grant = bus.lsu_valid_i && (!bus.ex_valid_i || w_lsu_pri);
    assign w_ex_grant  = bus.ex_valid_i && !w_lsu_grant;
    assign w_accept    = w_ex_grant || w_lsu_grant;
    assign w_waddr     = w_lsu_grant ? bus.lsu_waddr_i : bus.ex_waddr_i;
    assign w_wdata     = w_lsu_grant ? bus.lsu_wdata_i : bus.ex_wdata_i;

    assign bus.ex_ready_o  = w_ex_grant;
    assign bus.lsu_ready_o = w_lsu_grant;

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_lsu_grant)
            w_busy_nxt[bus.lsu_waddr_i] = 1'b0;
        if (bus.issue_i)
            w_busy_nxt[bus.issue_waddr_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_busy     <= '0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_wen  <= w_accept && (w_waddr != 5'd0);
            if (w_accept) begin
                r_waddr <= w_waddr;
                r_wdata <= w_wdata;
            end
            if (!bus.lsu_valid_i || w_lsu_grant)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != CNT_MAX)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign bus.stall_o     = r_busy[bus.id_raddr1_i] | r_busy[bus.id_raddr2_i];
    assign bus.reg_wen_o   = r_wen;
    assign bus.reg_waddr_o = r_waddr;
    assign bus.reg_wdata_o = r_wdata;
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
Write-port arbiter and pending-write scoreboard for the 32x32 register file, which has 2 read ports, 1 write port, same-cycle write-to-read bypass, and x0 hardwired to zero.
- Shares the single write port between two writeback sources: the single-cycle EX result and the long-latency LSU/mul-div result.
- Tracks destinations of issued long-latency ops and raises a stall to ID until their results are written.
- Sits between EX/LSU writeback and the regfile write port; the stall goes to ID.

Parameters:
STARVE_MAX, 3, consecutive lost-arbitration cycles after which LSU gets priority (1..15)
CNT_W, 4, width of the starvation counter

Ports:
clk  in  1  clock
rst  in  1  reset
ex_valid_i  in  1  EX write request
ex_waddr_i  in  5  EX destination register
ex_wdata_i  in  32  EX write data
ex_ready_o  out  1  EX request granted this cycle
lsu_valid_i  in  1  LSU write request
lsu_waddr_i  in  5  LSU destination register
lsu_wdata_i  in  32  LSU write data
lsu_ready_o  out  1  LSU request granted this cycle
issue_i  in  1  long-latency op issued this cycle
issue_waddr_i  in  5  destination of the issued op
id_raddr1_i  in  5  ID source register 1
id_raddr2_i  in  5  ID source register 2
stall_o  out  1  ID must hold (operand pending)
reg_wen_o  out  1  regfile write enable
reg_waddr_o  out  5  regfile write address
reg_wdata_o  out  32  regfile write data

Behaviour:
Reset and clock:
- rst is synchronous, active-low; clock is clk.
- While rst==0: reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, all busy bits 0, starvation counter 0.
- Any in-flight grant or pending entry is discarded; stall_o=0.

Arbitration (combinational ready; accept = valid && ready):
- lsu_pri = (wait_cnt >= STARVE_MAX).
- Only EX valid: EX granted. Only LSU valid: LSU granted.
- Both valid: EX granted unless lsu_pri, in which case LSU granted.
- At most one of ex_ready_o / lsu_ready_o is high. Both are 0 when neither requester is valid.
- A requester that is not granted holds valid, waddr and wdata stable until granted.

Write path (1-cycle latency):
- Winner's waddr/wdata are registered to reg_waddr_o/reg_wdata_o at the next edge.
- reg_wen_o=1 for exactly one cycle per accept, except waddr==0: accepted and acknowledged, but reg_wen_o=0.
- No accept in a cycle: reg_wen_o=0 next cycle; waddr/wdata hold their last values.

Starvation counter:
- wait_cnt increments when lsu_valid_i && !lsu_ready_o, saturating at 2^CNT_W-1.
- Clears to 0 on LSU accept or when lsu_valid_i==0.

Scoreboard (busy[31:1]; busy[0] is constant 0):
- issue_i with issue_waddr_i!=0 sets busy[issue_waddr_i] at the next edge.
- LSU accept clears busy[lsu_waddr_i] at the next edge, the same edge that registers reg_wen_o. The regfile bypass then supplies the data to ID in that cycle.
- Set and clear of the same address in the same cycle: set wins.
- EX writes never change busy bits.
- stall_o = busy[id_raddr1_i] | busy[id_raddr2_i], purely combinational from the registered busy bits. Address 0 never stalls.

Test Plan:
- Reset: drive rst=0 with all valids high -> reg_wen_o=0, stall_o=0, readies may assert but nothing registers. Release -> first grant writes on the following cycle.
- Single EX write: ex_valid_i=1, waddr=5, wdata=0xDEADBEEF at cycle T -> ex_ready_o=1 at T; reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF at T+1 only.
- Contention and starvation: EX and LSU both valid continuously, STARVE_MAX=3 -> EX wins at T, T+1, T+2; LSU wins at T+3; EX wins at T+4. Never both readies high.
- Scoreboard: issue_i, waddr=7 at T; id_raddr1_i=7 -> stall_o=1 from T+1. LSU accept of waddr 7 at T+4 -> stall_o=0 and reg_wen_o=1 to x7 at T+5.
- x0 and collision: EX write to x0 -> ex_ready_o=1, reg_wen_o stays 0. LSU accept for x9 while issue_i targets x9 in the same cycle -> busy[9] stays 1.
- Reset mid-operation: busy[3]=1 and LSU waiting with wait_cnt=2, then pulse rst=0 -> stall_o=0 and wait_cnt=0 after the reset edge. The first post-reset contention cycle goes to EX.
